// File: rtl/player_turn_ctrl_if.sv
// Bundles the player-turn controller's sequence, button and turn-timer signals.
// Signal suffixes are named from the controller's point of view.
interface player_turn_ctrl_if #(
  parameter int SYM_W  = 2,
  parameter int LEN_W  = 4,
  parameter int TIME_W = 4
);
  logic              start_i;
  logic [LEN_W-1:0]  seq_len_i;
  logic [SYM_W-1:0]  exp_sym_i;
  logic              btn_valid_i;
  logic [SYM_W-1:0]  btn_sym_i;
  logic              tick_i;
  logic [TIME_W-1:0] tempo_i;
  logic              end_time_i;
  logic              cnt_r_o;
  logic              cnt_e_o;
  logic [LEN_W-1:0]  idx_o;
  logic [TIME_W-1:0] time_left_o;
  logic              busy_o;
  logic              win_o;
  logic              lose_o;
  logic              cause_o;

  modport slave (
    input  start_i, seq_len_i, exp_sym_i, btn_valid_i, btn_sym_i,
           tick_i, tempo_i, end_time_i,
    output cnt_r_o, cnt_e_o, idx_o, time_left_o, busy_o, win_o, lose_o, cause_o
  );

  modport master (
    output start_i, seq_len_i, exp_sym_i, btn_valid_i, btn_sym_i,
           tick_i, tempo_i, end_time_i,
    input  cnt_r_o, cnt_e_o, idx_o, time_left_o, busy_o, win_o, lose_o, cause_o
  );
endinterface

// File: rtl/player_turn_ctrl.sv
// Genius player-turn controller: checks presses against the sequence, one-cycle win/lose pulse
// the cycle after the judging edge; no backpressure, presses outside WAIT are dropped.
module player_turn_ctrl #(
  parameter int SYM_W  = 2,
  parameter int LEN_W  = 4,
  parameter int TIME_W = 4
) (
  input  logic              clk_i,
  input  logic              r_n_i,
  player_turn_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARM, WAIT, DONE} state_t;

  state_t           state_q;
  logic [LEN_W-1:0] idx_q;
  logic [LEN_W-1:0] len_q;
  logic             win_q;
  logic             lose_q;
  logic             cause_q;
  logic             end_q;

  logic timeout_ev;
  logic sym_ok;
  logic last_sym;

  // Only a fresh rising edge of the wrap flag counts, never a level left over from before.
  assign timeout_ev = bus.end_time_i & ~end_q;
  assign sym_ok     = (bus.btn_sym_i == bus.exp_sym_i);
  assign last_sym   = (idx_q == (len_q - LEN_W'(1)));

  always_ff @(posedge clk_i) begin
    if (!r_n_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      cause_q <= 1'b0;
      end_q   <= 1'b1;
    end else begin
      end_q  <= bus.end_time_i;
      win_q  <= 1'b0;
      lose_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            len_q   <= (bus.seq_len_i == '0) ? LEN_W'(1) : bus.seq_len_i;
            idx_q   <= '0;
            state_q <= ARM;
          end
        end
        ARM: state_q <= WAIT;
        WAIT: begin
          // A press in the same cycle as the timeout edge takes priority.
          if (bus.btn_valid_i) begin
            if (sym_ok && last_sym) begin
              win_q   <= 1'b1;
              state_q <= DONE;
            end else if (sym_ok) begin
              idx_q   <= idx_q + LEN_W'(1);
              state_q <= ARM;
            end else begin
              lose_q  <= 1'b1;
              cause_q <= 1'b0;
              state_q <= DONE;
            end
          end else if (timeout_ev) begin
            lose_q  <= 1'b1;
            cause_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cnt_r_o     = (state_q != WAIT);
  assign bus.cnt_e_o     = (state_q == WAIT) & bus.tick_i;
  assign bus.idx_o       = idx_q;
  assign bus.busy_o      = (state_q != IDLE);
  assign bus.win_o       = win_q;
  assign bus.lose_o      = lose_q;
  assign bus.cause_o     = cause_q;
  assign bus.time_left_o = ((state_q != WAIT) || (bus.tempo_i > TIME_W'(9))) ? '0
                         : (TIME_W'(9) - bus.tempo_i);

endmodule

// File: tb/tb_player_turn_ctrl.sv
// Directed bench for player_turn_ctrl; inputs change 1 time unit after a rising edge,
// outputs are checked there, well away from the next edge.
module tb_player_turn_ctrl;
  localparam int SYM_W  = 2;
  localparam int LEN_W  = 4;
  localparam int TIME_W = 4;

  logic clk = 1'b0;
  logic r_n = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  player_turn_ctrl_if #(.SYM_W(SYM_W), .LEN_W(LEN_W), .TIME_W(TIME_W)) bus ();

  player_turn_ctrl #(.SYM_W(SYM_W), .LEN_W(LEN_W), .TIME_W(TIME_W)) dut (
    .clk_i (clk),
    .r_n_i (r_n),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] sym, input logic [1:0] exp);
    bus.btn_valid_i = 1'b1;
    bus.btn_sym_i   = sym;
    bus.exp_sym_i   = exp;
    cyc();
    bus.btn_valid_i = 1'b0;
  endtask

  task automatic start_turn(input logic [3:0] len);
    bus.start_i   = 1'b1;
    bus.seq_len_i = len;
    cyc();
    bus.start_i   = 1'b0;
  endtask

  initial begin
    bus.start_i     = 1'b0;
    bus.seq_len_i   = '0;
    bus.exp_sym_i   = '0;
    bus.btn_valid_i = 1'b0;
    bus.btn_sym_i   = '0;
    bus.tick_i      = 1'b1;
    bus.tempo_i     = 4'd3;
    bus.end_time_i  = 1'b1;

    // Reset state
    cyc();
    cyc();
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_idx", bus.idx_o, 0);
    chk("rst_win", bus.win_o, 0);
    chk("rst_lose", bus.lose_o, 0);
    chk("rst_cause", bus.cause_o, 0);
    chk("rst_cnt_r", bus.cnt_r_o, 1);
    chk("rst_cnt_e", bus.cnt_e_o, 0);
    chk("rst_tleft", bus.time_left_o, 0);
    r_n         = 1'b1;
    bus.tick_i  = 1'b0;
    bus.tempo_i = 4'd0;

    // Turn 1: length 3, presses 2,0,3 all correct; end_time stays high (no edge)
    start_turn(4'd3);
    chk("t1_arm_busy", bus.busy_o, 1);
    chk("t1_arm_cnt_r", bus.cnt_r_o, 1);
    cyc();
    chk("t1_wait_cnt_r", bus.cnt_r_o, 0);
    bus.tick_i = 1'b1;
    #1 chk("t1_cnt_e_hi", bus.cnt_e_o, 1);
    bus.tick_i = 1'b0;
    #1 chk("t1_cnt_e_lo", bus.cnt_e_o, 0);
    bus.tempo_i = 4'd4;
    #1 chk("t1_tleft4", bus.time_left_o, 5);
    bus.tempo_i = 4'd12;
    #1 chk("t1_tleft_ovr", bus.time_left_o, 0);
    bus.tempo_i = 4'd0;
    #1 chk("t1_tleft0", bus.time_left_o, 9);
    cyc();
    chk("t1_stale_end", bus.lose_o, 0);
    press(2'd2, 2'd2);
    chk("t1_p1_idx", bus.idx_o, 1);
    chk("t1_p1_cnt_r", bus.cnt_r_o, 1);
    chk("t1_p1_tleft", bus.time_left_o, 0);
    cyc();
    press(2'd0, 2'd0);
    chk("t1_p2_idx", bus.idx_o, 2);
    chk("t1_p2_cnt_r", bus.cnt_r_o, 1);
    cyc();
    press(2'd3, 2'd3);
    chk("t1_win", bus.win_o, 1);
    chk("t1_nolose", bus.lose_o, 0);
    chk("t1_idx_final", bus.idx_o, 2);
    cyc();
    chk("t1_win_fall", bus.win_o, 0);
    chk("t1_idle", bus.busy_o, 0);

    // Turn 2: wrong colour; a press during ARM is ignored
    bus.end_time_i = 1'b0;
    start_turn(4'd2);
    press(2'd1, 2'd3);
    chk("t2_arm_ignore", bus.lose_o, 0);
    chk("t2_arm_busy", bus.cnt_r_o, 0);
    press(2'd1, 2'd3);
    chk("t2_lose", bus.lose_o, 1);
    chk("t2_cause", bus.cause_o, 0);
    chk("t2_idx", bus.idx_o, 0);
    chk("t2_nowin", bus.win_o, 0);
    cyc();
    chk("t2_idle", bus.busy_o, 0);
    chk("t2_lose_fall", bus.lose_o, 0);

    // Turn 3: timeout, seq_len 0 treated as 1; time_left counts down
    start_turn(4'd0);
    cyc();
    bus.tick_i = 1'b1;
    for (int t = 0; t < 10; t++) begin
      bus.tempo_i = 4'(t);
      #1 chk("t3_tleft", bus.time_left_o, 32'(9 - t));
      cyc();
    end
    bus.tick_i     = 1'b0;
    bus.tempo_i    = 4'd0;
    bus.end_time_i = 1'b1;
    cyc();
    chk("t3_lose", bus.lose_o, 1);
    chk("t3_cause", bus.cause_o, 1);
    cyc();
    chk("t3_idle", bus.busy_o, 0);
    chk("t3_cause_hold", bus.cause_o, 1);

    // Turn 4: end_time already high from before; only a fresh edge times out
    start_turn(4'd1);
    cyc();
    cyc();
    cyc();
    chk("t4_no_false", bus.lose_o, 0);
    chk("t4_busy", bus.busy_o, 1);
    bus.end_time_i = 1'b0;
    cyc();
    chk("t4_low", bus.lose_o, 0);
    bus.end_time_i = 1'b1;
    cyc();
    chk("t4_lose", bus.lose_o, 1);
    chk("t4_cause", bus.cause_o, 1);
    cyc();

    // Turn 5: correct final press in the same cycle as the timeout edge
    bus.end_time_i = 1'b0;
    start_turn(4'd0);
    cyc();
    cyc();
    bus.end_time_i = 1'b1;
    press(2'd1, 2'd1);
    chk("t5_win", bus.win_o, 1);
    chk("t5_nolose", bus.lose_o, 0);
    cyc();
    chk("t5_idle", bus.busy_o, 0);

    // Turn 6: start ignored mid-WAIT, then reset aborts a pending win
    bus.end_time_i = 1'b0;
    start_turn(4'd2);
    cyc();
    press(2'd0, 2'd0);
    cyc();
    start_turn(4'd5);
    chk("t6_start_ign_idx", bus.idx_o, 1);
    chk("t6_start_ign_wait", bus.cnt_r_o, 0);
    r_n = 1'b0;
    press(2'd2, 2'd2);
    r_n = 1'b1;
    chk("t6_rst_busy", bus.busy_o, 0);
    chk("t6_rst_idx", bus.idx_o, 0);
    chk("t6_rst_win", bus.win_o, 0);
    chk("t6_rst_lose", bus.lose_o, 0);
    chk("t6_rst_cnt_r", bus.cnt_r_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/player_turn_ctrl.md
Name: player_turn_ctrl

Overview:
- Player-turn controller for the Genius game; sits directly downstream of the 0–9 turn timer (counter_time) and consumes its `tempo`/`end_time` outputs.
- Drives that timer's reset and enable, walks through the expected colour sequence and checks each button press.
- Ends the turn with a one-cycle win or lose pulse; lose carries a cause (wrong colour or timeout).
- The timer restarts after every correct press, so each press has its own 10-tick window.

Parameters:
- SYM_W, 2, width of a colour symbol (4 colours)
- LEN_W, 4, width of sequence length and index (max 15 symbols)
- TIME_W, 4, width of the timer value consumed from the turn timer

Ports:
- clk_i  in  1  system clock; all logic on rising edge
- r_n_i  in  1  reset
- start_i  in  1  one-cycle pulse: begin a player turn
- seq_len_i  in  LEN_W  symbols the player must enter; sampled on start_i
- exp_sym_i  in  SYM_W  expected symbol at index idx_o, supplied combinationally by the sequence memory
- btn_valid_i  in  1  one-cycle pulse: debounced button press
- btn_sym_i  in  SYM_W  colour of the pressed button; valid with btn_valid_i
- tick_i  in  1  1 Hz enable pulse from the prescaler
- tempo_i  in  TIME_W  current timer value
- end_time_i  in  1  timer wrap flag (level; may be stale or X after power-up)
- cnt_r_o  out  1  active-high reset to the turn timer
- cnt_e_o  out  1  enable to the turn timer
- idx_o  out  LEN_W  current sequence index
- time_left_o  out  TIME_W  remaining seconds, 9 - tempo_i; 0 outside WAIT
- busy_o  out  1  high in any state except IDLE
- win_o  out  1  one-cycle pulse: whole sequence entered correctly
- lose_o  out  1  one-cycle pulse: turn failed
- cause_o  out  1  lose cause: 0 = wrong symbol, 1 = timeout; held until the next lose_o

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is synchronous and active-low: r_n_i = 0 at a rising clk_i edge resets the block.
- Reset values:
  - state = IDLE; idx_o = 0; len_q = 0; win_o = 0; lose_o = 0; cause_o = 0.
  - end_q (registered copy of end_time_i) resets to 1, so a stale or X high flag never creates a false timeout edge.
- State register: IDLE, ARM, WAIT, DONE.
- IDLE:
  - cnt_r_o = 1, cnt_e_o = 0.
  - On start_i: len_q <= (seq_len_i == 0) ? 1 : seq_len_i; idx_o <= 0; go to ARM.
- ARM (exactly 1 cycle):
  - cnt_r_o = 1, which clears the timer to 0.
  - Go to WAIT.
- WAIT:
  - cnt_r_o = 0; cnt_e_o = tick_i.
  - Timeout event = end_time_i & ~end_q (rising edge only).
  - btn_valid_i with btn_sym_i == exp_sym_i:
    - if idx_o == len_q - 1: win_o <= 1, go to DONE;
    - otherwise: idx_o <= idx_o + 1, go to ARM (timer restarts).
  - btn_valid_i with btn_sym_i != exp_sym_i: lose_o <= 1, cause_o <= 0, go to DONE.
  - Timeout event with no btn_valid_i: lose_o <= 1, cause_o <= 1, go to DONE.
  - Same-cycle button press and timeout edge: the button is evaluated and the timeout is ignored.
- DONE (1 cycle):
  - win_o/lose_o fall to 0; cnt_r_o = 1; go to IDLE.
- end_q <= end_time_i every cycle in every state.
- Latency:
  - start_i at edge n → ARM from n+1 → WAIT from n+2.
  - Judged press at edge m → win_o/lose_o high for the cycle after edge m.
- Ignored inputs:
  - start_i outside IDLE.
  - btn_valid_i outside WAIT (including during ARM).
- Other rules:
  - idx_o never exceeds len_q - 1; increment is modulo 2^LEN_W and can never wrap given the rule above.
  - time_left_o: unsigned subtraction; if tempo_i > 9, output 0.
  - Reset asserted in any state returns to IDLE on that edge and aborts any pending pulse; no win_o/lose_o is emitted.

Test Plan:
- Reset, then start_i with seq_len_i=3, correct presses 2,0,3 at exp_sym_i 2,0,3 → idx_o steps 0→1→2; cnt_r_o high 1 cycle after each correct non-final press; win_o one cycle after the third press; lose_o stays 0.
- seq_len_i=2; first press btn_sym_i=1 with exp_sym_i=3 → lose_o pulse, cause_o=1'b0, idx_o=0, back to IDLE 2 cycles later.
- seq_len_i=1; no press, 10 tick_i pulses → timer wraps, end_time_i rises, lose_o pulse with cause_o=1; time_left_o counts 9..0 along the way.
- end_time_i held high from the previous turn, new start_i → no lose_o until 10 fresh ticks produce a new rising edge.
- btn_valid_i (correct, final symbol) in the same cycle as the end_time_i rising edge → win_o=1, lose_o=0.
- Mid-WAIT with idx_o=1, r_n_i=0 for one edge → state IDLE, idx_o=0, no win_o/lose_o; start_i during WAIT is ignored (idx_o unchanged).
